gf_seq_mult: RTL

Parametrised sequential multiplier processing `DIGIT_WIDTH` bits of operand b per cycle, with three runtime modes:
- integer multiply;
- carry-less (GF(2)[x]) multiply;
- GF(2^m) modular multiply, where a carry-less product is reduced by a runtime irreducible polynomial.

It replaces the single-mode bit-serial `mult` in the GF datapath and is checked against `cl_rca_mult` for modes 0/1.

---
 rtl/gf_mult_pkg.sv | 21 ++
 rtl/gf_digit_step.sv | 34 +++
 rtl/gf_seq_mult.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gf_mult_pkg.sv
// Shared types and constants for the multi-mode sequential GF/integer multiplier.
// Provides the FSM state encoding, the operating-mode codes and the operand-width port sizing helper.
package gf_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INT = 2'd0;
    localparam logic [1:0] MODE_CL  = 2'd1;
    localparam logic [1:0] MODE_GF  = 2'd2;

    // Width of a field able to hold any operand width from 0 up to dw inclusive.
    function automatic int width_bits(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One multiply step: folds a shifted copy of operand a into the accumulator
// for every set bit of the current digit of b, with integer add or carry-less XOR.
module gf_digit_step #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4,
    parameter int IDX_WIDTH   = 4
) (
    input  logic [2*DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DIGIT_WIDTH-1:0]  i_digit,
    input  logic [IDX_WIDTH-1:0]    i_digit_idx,
    input  logic                    i_carry,
    output logic [2*DATA_WIDTH-1:0] o_acc
);

    localparam int ACC_W = 2 * DATA_WIDTH;

    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_term;

    always_comb begin
        w_sum  = i_acc;
        w_term = '0;
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
            w_term = ACC_W'(i_a) << (32'(i_digit_idx) * DIGIT_WIDTH + j);
            if (i_digit[j]) begin
                w_sum = i_carry ? (w_sum + w_term) : (w_sum ^ w_term);
            end
        end
    end

    assign o_acc = w_sum;

endmodule

// File: rtl/gf_seq_mult.sv
// Digit-serial multiplier with integer, carry-less and GF(2^m) modes.
// The FSM latches masked operands, runs the digit steps, then reduces bit by bit in GF mode.
module gf_seq_mult
    import gf_mult_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                op_enable,
    input  logic [1:0]                          op_mode,
    input  logic [width_bits(DATA_WIDTH)-1:0]   in_width,
    input  logic [DATA_WIDTH-1:0]               in_mult_a,
    input  logic [DATA_WIDTH-1:0]               in_mult_b,
    input  logic [DATA_WIDTH-1:0]               in_poly,
    output logic [2*DATA_WIDTH-1:0]             out_mult_result,
    output logic                                op_finish,
    output logic                                op_busy
);

    localparam int WW    = width_bits(DATA_WIDTH);
    localparam int ACC_W = 2 * DATA_WIDTH;
    localparam int NDIG  = (DATA_WIDTH + DIGIT_WIDTH - 1) / DIGIT_WIDTH;
    localparam int IW    = $clog2(NDIG + 1);
    localparam int RW    = $clog2(ACC_W);

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_mode;
    logic [WW-1:0]         r_width;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_poly;
    logic [ACC_W-1:0]      r_acc;
    logic [IW-1:0]         r_digit;
    logic [RW-1:0]         r_red_idx;
    logic [ACC_W-1:0]      r_result;
    logic                  r_finish;

    logic [WW-1:0]          w_width_clamped;
    logic [DATA_WIDTH-1:0]  w_in_mask;
    logic [IW-1:0]          w_last_digit;
    logic [DIGIT_WIDTH-1:0] w_digit;
    logic                   w_carry;
    logic [ACC_W-1:0]       w_acc_step;
    logic [RW-1:0]          w_red_shift;
    logic [ACC_W-1:0]       w_red_term;
    logic [ACC_W-1:0]       w_acc_reduced;

    // Width 0 means a 1-bit operand; anything above DATA_WIDTH saturates.
    always_comb begin
        w_width_clamped = in_width;
        if (in_width == '0) begin
            w_width_clamped = WW'(1);
        end else if (in_width > WW'(DATA_WIDTH)) begin
            w_width_clamped = WW'(DATA_WIDTH);
        end
    end

    assign w_in_mask    = DATA_WIDTH'((ACC_W'(1) << w_width_clamped) - ACC_W'(1));
    assign w_last_digit = IW'((32'(r_width) + DIGIT_WIDTH - 1) / DIGIT_WIDTH - 1);
    assign w_digit      = DIGIT_WIDTH'(r_b >> (32'(r_digit) * DIGIT_WIDTH));
    assign w_carry      = (r_mode == MODE_INT);

    gf_digit_step #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DIGIT_WIDTH (DIGIT_WIDTH),
        .IDX_WIDTH   (IW)
    ) u_step (
        .i_acc       (r_acc),
        .i_a         (r_a),
        .i_digit     (w_digit),
        .i_digit_idx (r_digit),
        .i_carry     (w_carry),
        .o_acc       (w_acc_step)
    );

    // Clearing bit i subtracts x^(i-w) * (x^w + poly); lower bits absorb the poly terms.
    assign w_red_shift   = RW'(r_red_idx - RW'(r_width));
    assign w_red_term    = (ACC_W'(1) << r_red_idx) | (ACC_W'(r_poly) << w_red_shift);
    assign w_acc_reduced = r_acc[r_red_idx] ? (r_acc ^ w_red_term) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        op_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_enable) begin
                    w_next_state = ST_MULT;
                end
            end
            ST_MULT: begin
                op_busy = 1'b1;
                if (!op_enable) begin
                    w_next_state = ST_IDLE;
                end else if (r_digit == w_last_digit) begin
                    w_next_state = (r_mode == MODE_GF && r_width > WW'(1)) ? ST_REDUCE : ST_DONE;
                end
            end
            ST_REDUCE: begin
                op_busy = 1'b1;
                if (!op_enable) begin
                    w_next_state = ST_IDLE;
                end else if (r_red_idx == RW'(r_width)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!op_enable) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The result register loads from the final accumulator value on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= '0;
            r_width   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_poly    <= '0;
            r_acc     <= '0;
            r_digit   <= '0;
            r_red_idx <= '0;
            r_result  <= '0;
            r_finish  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_enable) begin
                        r_mode  <= op_mode;
                        r_width <= w_width_clamped;
                        r_a     <= in_mult_a & w_in_mask;
                        r_b     <= in_mult_b & w_in_mask;
                        r_poly  <= in_poly & w_in_mask;
                        r_acc   <= '0;
                        r_digit <= '0;
                    end
                end
                ST_MULT: begin
                    if (op_enable) begin
                        r_acc     <= w_acc_step;
                        r_digit   <= r_digit + IW'(1);
                        r_red_idx <= RW'(2 * 32'(r_width) - 2);
                        if (w_next_state == ST_DONE) begin
                            r_result <= w_acc_step;
                            r_finish <= 1'b1;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (op_enable) begin
                        r_acc     <= w_acc_reduced;
                        r_red_idx <= r_red_idx - RW'(1);
                        if (w_next_state == ST_DONE) begin
                            r_result <= w_acc_reduced;
                            r_finish <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!op_enable) begin
                        r_finish <= 1'b0;
                    end
                end
                default: r_finish <= 1'b0;
            endcase
        end
    end

    assign out_mult_result = r_result;
    assign op_finish       = r_finish;

endmodule
